// File: rtl/merge_avlstrm_pkg.sv
// Shared definitions for the packet-atomic 2:1 Avalon-ST merge.
//   AVL_DW / AVL_EW : default data and empty widths of the stream.
//   merge_state_t   : packet-lock state of the merge arbiter.
package merge_avlstrm_pkg;

    localparam int AVL_DW = 512;
    localparam int AVL_EW = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } merge_state_t;

endpackage

// File: rtl/merge_avlstrm_stats_cnt.sv
// Per-port packet statistics: two free-running 32-bit counters that wrap.
//   Clk, Rst_n   : clock, asynchronous active-low reset
//   beat_i       : a beat transferred on the observed port this cycle
//   sop_i, eop_i : framing of that beat
//   pkt_cnt_o    : number of transferred eop beats
//   sop_cnt_o    : number of transferred sop beats
module stats_cnt
    import merge_avlstrm_pkg::*;
(
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        beat_i,
    input  logic        sop_i,
    input  logic        eop_i,
    output logic [31:0] pkt_cnt_o,
    output logic [31:0] sop_cnt_o
);

    logic [31:0] pkt_q, pkt_d;
    logic [31:0] sop_q, sop_d;

    always_comb begin
        pkt_d = pkt_q;
        sop_d = sop_q;
        if (beat_i && eop_i) pkt_d = pkt_q + 32'd1;
        if (beat_i && sop_i) sop_d = sop_q + 32'd1;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            pkt_q <= '0;
            sop_q <= '0;
        end else begin
            pkt_q <= pkt_d;
            sop_q <= sop_d;
        end
    end

    assign pkt_cnt_o = pkt_q;
    assign sop_cnt_o = sop_q;

endmodule

// File: rtl/merge_avlstrm.sv
// Packet-atomic 2:1 merge of two Avalon-ST streams onto one output.
// Packets are arbitrated round-robin; once a sop is taken from an input the
// other input stalls until that packet's eop. One registered output stage.
//   Clk, Rst_n             : clock, asynchronous active-low reset
//   in0_* / in1_*          : upstream streams (valid/data/empty/channel/sop/eop
//                            in, ready/almost_full out)
//   out_*                  : merged downstream stream (ready/almost_full in)
//   stats_in_pkt0/1, stats_out_pkt        : eop beats accepted per port
//   stats_in_pkt0_s/1_s, stats_out_pkt_s  : sop beats accepted per port
//   stats_orphan           : non-sop beats dropped while no packet is locked
module merge_avlstrm
    import merge_avlstrm_pkg::*;
#(
    parameter int DW          = AVL_DW,
    parameter int EW          = AVL_EW,
    parameter int CW          = 1,
    parameter int TAG_CHANNEL = 1
) (
    input  logic          Clk,
    input  logic          Rst_n,
    input  logic          in0_valid_i,
    output logic          in0_ready_o,
    input  logic [DW-1:0] in0_data_i,
    input  logic [EW-1:0] in0_empty_i,
    input  logic [CW-1:0] in0_channel_i,
    input  logic          in0_sop_i,
    input  logic          in0_eop_i,
    output logic          in0_almost_full_o,
    input  logic          in1_valid_i,
    output logic          in1_ready_o,
    input  logic [DW-1:0] in1_data_i,
    input  logic [EW-1:0] in1_empty_i,
    input  logic [CW-1:0] in1_channel_i,
    input  logic          in1_sop_i,
    input  logic          in1_eop_i,
    output logic          in1_almost_full_o,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [DW-1:0] out_data_o,
    output logic [EW-1:0] out_empty_o,
    output logic [CW-1:0] out_channel_o,
    output logic          out_sop_o,
    output logic          out_eop_o,
    input  logic          out_almost_full_i,
    output logic [31:0]   stats_in_pkt0,
    output logic [31:0]   stats_in_pkt1,
    output logic [31:0]   stats_out_pkt,
    output logic [31:0]   stats_in_pkt0_s,
    output logic [31:0]   stats_in_pkt1_s,
    output logic [31:0]   stats_out_pkt_s,
    output logic [31:0]   stats_orphan
);

    merge_state_t  state_q, state_d;
    logic          ptr_q, ptr_d;
    logic          grant;
    logic          load, acc, fwd, orphan, locked;
    logic          sel_valid, sel_sop, sel_eop;
    logic [DW-1:0] sel_data;
    logic [EW-1:0] sel_empty;
    logic [CW-1:0] sel_channel, out_channel_d;

    logic          out_valid_q;
    logic [DW-1:0] out_data_q;
    logic [EW-1:0] out_empty_q;
    logic [CW-1:0] out_channel_q;
    logic          out_sop_q, out_eop_q;
    logic [31:0]   orphan_q;

    assign locked = (state_q != IDLE);

    // Grant: fixed while locked; in IDLE prefer sop candidates, then orphans,
    // breaking ties with the round-robin pointer.
    always_comb begin
        grant = 1'b0;
        case (state_q)
            LOCK0: grant = 1'b0;
            LOCK1: grant = 1'b1;
            default: begin
                if (in0_valid_i && in0_sop_i && in1_valid_i && in1_sop_i) grant = ptr_q;
                else if (in0_valid_i && in0_sop_i)                         grant = 1'b0;
                else if (in1_valid_i && in1_sop_i)                         grant = 1'b1;
                else if (in0_valid_i && in1_valid_i)                       grant = ptr_q;
                else if (in1_valid_i)                                      grant = 1'b1;
                else                                                       grant = 1'b0;
            end
        endcase
    end

    assign load        = !out_valid_q || out_ready_i;
    assign in0_ready_o = load && !grant;
    assign in1_ready_o = load && grant;

    assign in0_almost_full_o = out_almost_full_i;
    assign in1_almost_full_o = out_almost_full_i;

    assign sel_valid   = grant ? in1_valid_i   : in0_valid_i;
    assign sel_data    = grant ? in1_data_i    : in0_data_i;
    assign sel_empty   = grant ? in1_empty_i   : in0_empty_i;
    assign sel_channel = grant ? in1_channel_i : in0_channel_i;
    assign sel_sop     = grant ? in1_sop_i     : in0_sop_i;
    assign sel_eop     = grant ? in1_eop_i     : in0_eop_i;

    assign out_channel_d = (TAG_CHANNEL != 0) ? CW'(grant) : sel_channel;

    // A beat is forwarded when locked or when it opens a packet; a non-sop
    // beat taken while unlocked is consumed and dropped.
    assign acc    = load && sel_valid;
    assign fwd    = acc && (locked || sel_sop);
    assign orphan = acc && !locked && !sel_sop;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        if (fwd) begin
            if (sel_eop) begin
                state_d = IDLE;
                ptr_d   = !grant;
            end else begin
                state_d = grant ? LOCK1 : LOCK0;
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_empty_q   <= '0;
            out_channel_q <= '0;
            out_sop_q     <= 1'b0;
            out_eop_q     <= 1'b0;
        end else if (load) begin
            out_valid_q <= fwd;
            if (fwd) begin
                out_data_q    <= sel_data;
                out_empty_q   <= sel_empty;
                out_channel_q <= out_channel_d;
                out_sop_q     <= sel_sop;
                out_eop_q     <= sel_eop;
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) orphan_q <= '0;
        else if (orphan) orphan_q <= orphan_q + 32'd1;
    end

    assign out_valid_o   = out_valid_q;
    assign out_data_o    = out_data_q;
    assign out_empty_o   = out_empty_q;
    assign out_channel_o = out_channel_q;
    assign out_sop_o     = out_sop_q;
    assign out_eop_o     = out_eop_q;
    assign stats_orphan  = orphan_q;

    stats_cnt u_stats_in0 (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .beat_i    (fwd && !grant),
        .sop_i     (sel_sop),
        .eop_i     (sel_eop),
        .pkt_cnt_o (stats_in_pkt0),
        .sop_cnt_o (stats_in_pkt0_s)
    );

    stats_cnt u_stats_in1 (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .beat_i    (fwd && grant),
        .sop_i     (sel_sop),
        .eop_i     (sel_eop),
        .pkt_cnt_o (stats_in_pkt1),
        .sop_cnt_o (stats_in_pkt1_s)
    );

    stats_cnt u_stats_out (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .beat_i    (out_valid_q && out_ready_i),
        .sop_i     (out_sop_q),
        .eop_i     (out_eop_q),
        .pkt_cnt_o (stats_out_pkt),
        .sop_cnt_o (stats_out_pkt_s)
    );

endmodule

// File: tb/tb_merge_avlstrm.sv
module tb_merge_avlstrm;

    localparam int DW = 32;
    localparam int EW = 2;
    localparam int CW = 1;

    logic          Clk = 1'b0;
    logic          Rst_n;
    logic          in0_valid_i, in0_ready_o, in0_sop_i, in0_eop_i, in0_almost_full_o;
    logic [DW-1:0] in0_data_i;
    logic [EW-1:0] in0_empty_i;
    logic [CW-1:0] in0_channel_i;
    logic          in1_valid_i, in1_ready_o, in1_sop_i, in1_eop_i, in1_almost_full_o;
    logic [DW-1:0] in1_data_i;
    logic [EW-1:0] in1_empty_i;
    logic [CW-1:0] in1_channel_i;
    logic          out_valid_o, out_ready_i, out_sop_o, out_eop_o, out_almost_full_i;
    logic [DW-1:0] out_data_o;
    logic [EW-1:0] out_empty_o;
    logic [CW-1:0] out_channel_o;
    logic [31:0]   stats_in_pkt0, stats_in_pkt1, stats_out_pkt;
    logic [31:0]   stats_in_pkt0_s, stats_in_pkt1_s, stats_out_pkt_s, stats_orphan;

    int n_cmp = 0;
    int n_err = 0;

    always #5 Clk = ~Clk;

    merge_avlstrm #(.DW(DW), .EW(EW), .CW(CW), .TAG_CHANNEL(1)) dut (
        .Clk               (Clk),
        .Rst_n             (Rst_n),
        .in0_valid_i       (in0_valid_i),
        .in0_ready_o       (in0_ready_o),
        .in0_data_i        (in0_data_i),
        .in0_empty_i       (in0_empty_i),
        .in0_channel_i     (in0_channel_i),
        .in0_sop_i         (in0_sop_i),
        .in0_eop_i         (in0_eop_i),
        .in0_almost_full_o (in0_almost_full_o),
        .in1_valid_i       (in1_valid_i),
        .in1_ready_o       (in1_ready_o),
        .in1_data_i        (in1_data_i),
        .in1_empty_i       (in1_empty_i),
        .in1_channel_i     (in1_channel_i),
        .in1_sop_i         (in1_sop_i),
        .in1_eop_i         (in1_eop_i),
        .in1_almost_full_o (in1_almost_full_o),
        .out_valid_o       (out_valid_o),
        .out_ready_i       (out_ready_i),
        .out_data_o        (out_data_o),
        .out_empty_o       (out_empty_o),
        .out_channel_o     (out_channel_o),
        .out_sop_o         (out_sop_o),
        .out_eop_o         (out_eop_o),
        .out_almost_full_i (out_almost_full_i),
        .stats_in_pkt0     (stats_in_pkt0),
        .stats_in_pkt1     (stats_in_pkt1),
        .stats_out_pkt     (stats_out_pkt),
        .stats_in_pkt0_s   (stats_in_pkt0_s),
        .stats_in_pkt1_s   (stats_in_pkt1_s),
        .stats_out_pkt_s   (stats_out_pkt_s),
        .stats_orphan      (stats_orphan)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic drv0(input logic v, input logic s, input logic e, input logic [31:0] d);
        in0_valid_i = v; in0_sop_i = s; in0_eop_i = e; in0_data_i = d;
        in0_empty_i = e ? 2'd3 : 2'd0; in0_channel_i = 1'b1;
    endtask

    task automatic drv1(input logic v, input logic s, input logic e, input logic [31:0] d);
        in1_valid_i = v; in1_sop_i = s; in1_eop_i = e; in1_data_i = d;
        in1_empty_i = e ? 2'd1 : 2'd0; in1_channel_i = 1'b0;
    endtask

    function automatic logic [31:0] enc(input int port, input int pk, input int beat);
        return (32'(port) << 28) | (32'(pk) << 16) | 32'(beat);
    endfunction

    initial begin
        int p0, b0, p1, b1, idx, port, k0, k1;
        logic a0, a1;

        Rst_n = 1'b0;
        out_ready_i = 1'b1;
        out_almost_full_i = 1'b0;
        drv0(0, 0, 0, 32'h0);
        drv1(0, 0, 0, 32'h0);
        #7;
        chk("rst_out_valid", 32'(out_valid_o), 32'd0);
        chk("rst_out_data", out_data_o, 32'd0);
        chk("rst_out_flags", {28'd0, out_empty_o, out_sop_o, out_eop_o}, 32'd0);
        chk("rst_stats_out", stats_out_pkt, 32'd0);
        chk("rst_orphan", stats_orphan, 32'd0);
        Rst_n = 1'b1;

        out_almost_full_i = 1'b1;
        #1;
        chk("af_fwd0", 32'(in0_almost_full_o), 32'd1);
        chk("af_fwd1", 32'(in1_almost_full_o), 32'd1);
        out_almost_full_i = 1'b0;

        // in0 alone: 3-beat packet
        drv0(1, 1, 0, 32'hA1);
        #1;
        chk("A_rdy0", 32'(in0_ready_o), 32'd1);
        chk("A_rdy1", 32'(in1_ready_o), 32'd0);
        tick();
        chk("A_b1", {out_valid_o, out_sop_o, out_eop_o, 29'(out_data_o)}, {3'b110, 29'hA1});
        chk("A_b1_ch", 32'(out_channel_o), 32'd0);
        drv0(1, 0, 0, 32'hA2);
        tick();
        chk("A_b2", {out_valid_o, out_sop_o, out_eop_o, 29'(out_data_o)}, {3'b100, 29'hA2});
        drv0(1, 0, 1, 32'hA3);
        tick();
        chk("A_b3", {out_valid_o, out_sop_o, out_eop_o, 29'(out_data_o)}, {3'b101, 29'hA3});
        chk("A_b3_empty", 32'(out_empty_o), 32'd3);
        drv0(0, 0, 0, 32'h0);
        tick();
        chk("A_idle", 32'(out_valid_o), 32'd0);
        chk("A_in0_pkt", stats_in_pkt0, 32'd1);
        chk("A_in0_sop", stats_in_pkt0_s, 32'd1);
        chk("A_out_pkt", stats_out_pkt, 32'd1);

        // Both saturated with 4-beat packets, 4 per input; pointer now favours in1
        p0 = 0; b0 = 0; p1 = 0; b1 = 0; idx = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (p0 < 4) drv0(1, b0 == 0, b0 == 3, enc(0, p0, b0));
            else        drv0(0, 0, 0, 32'h0);
            if (p1 < 4) drv1(1, b1 == 0, b1 == 3, enc(1, p1, b1));
            else        drv1(0, 0, 0, 32'h0);
            #1;
            a0 = in0_ready_o && in0_valid_i;
            a1 = in1_ready_o && in1_valid_i;
            chk("B_excl", 32'(in0_ready_o && in1_ready_o), 32'd0);
            tick();
            if (a0) begin b0++; if (b0 == 4) begin b0 = 0; p0++; end end
            if (a1) begin b1++; if (b1 == 4) begin b1 = 0; p1++; end end
            if (idx < 32 && (idx > 0 || out_valid_o)) begin
                port = ((idx / 4) % 2 == 0) ? 1 : 0;
                chk("B_valid", 32'(out_valid_o), 32'd1);
                chk("B_data", out_data_o, enc(port, idx / 8, idx % 4));
                chk("B_chan", 32'(out_channel_o), 32'(port));
                idx++;
            end
        end
        chk("B_count", 32'(idx), 32'd32);
        chk("B_out_pkt", stats_out_pkt, 32'd9);
        chk("B_out_sop", stats_out_pkt_s, 32'd9);
        chk("B_in1_pkt", stats_in_pkt1, 32'd4);

        // Single-beat packets on both inputs every cycle
        k0 = 0; k1 = 0; idx = 0;
        for (int cyc = 0; cyc < 9; cyc++) begin
            if (k0 < 4) drv0(1, 1, 1, 32'h0C00 + 32'(k0)); else drv0(0, 0, 0, 32'h0);
            if (k1 < 4) drv1(1, 1, 1, 32'h1C00 + 32'(k1)); else drv1(0, 0, 0, 32'h0);
            #1;
            a0 = in0_ready_o && in0_valid_i;
            a1 = in1_ready_o && in1_valid_i;
            tick();
            if (a0) k0++;
            if (a1) k1++;
            if (idx < 8) begin
                port = (idx % 2 == 0) ? 1 : 0;
                chk("C_valid", 32'(out_valid_o), 32'd1);
                chk("C_data", out_data_o, (port == 1 ? 32'h1C00 : 32'h0C00) + 32'(idx / 2));
                chk("C_chan", 32'(out_channel_o), 32'(port));
                idx++;
            end else begin
                chk("C_drained", 32'(out_valid_o), 32'd0);
            end
        end
        chk("C_out_pkt", stats_out_pkt, 32'd17);

        // in0 locked, downstream stalls 5 cycles while in1 waits with a sop
        drv0(1, 1, 0, 32'hD0);
        tick();
        chk("D_b0", out_data_o, 32'hD0);
        drv0(1, 0, 0, 32'hD1);
        tick();
        chk("D_b1", out_data_o, 32'hD1);
        out_ready_i = 1'b0;
        drv0(1, 0, 0, 32'hD2);
        drv1(1, 1, 1, 32'hE0);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("D_stall_rdy", {30'd0, in0_ready_o, in1_ready_o}, 32'd0);
            tick();
            chk("D_hold", {out_valid_o, 31'(out_data_o)}, {1'b1, 31'hD1});
        end
        out_ready_i = 1'b1;
        #1;
        chk("D_resume_rdy", {30'd0, in0_ready_o, in1_ready_o}, 32'd2);
        tick();
        chk("D_b2", out_data_o, 32'hD2);
        drv0(1, 0, 1, 32'hD3);
        tick();
        chk("D_b3", {out_eop_o, 31'(out_data_o)}, {1'b1, 31'hD3});
        drv0(0, 0, 0, 32'h0);
        #1;
        chk("D_rdy1", 32'(in1_ready_o), 32'd1);
        tick();
        chk("D_e0", {out_sop_o, out_eop_o, 30'(out_data_o)}, {2'b11, 30'hE0});
        chk("D_e0_ch", 32'(out_channel_o), 32'd1);
        drv1(0, 0, 0, 32'h0);
        tick();
        chk("D_idle", 32'(out_valid_o), 32'd0);

        // Orphan beat on in1 while unlocked
        drv1(1, 0, 0, 32'hBAD);
        #1;
        chk("E_rdy", {30'd0, in0_ready_o, in1_ready_o}, 32'd1);
        tick();
        drv1(0, 0, 0, 32'h0);
        chk("E_no_out", 32'(out_valid_o), 32'd0);
        chk("E_orphan", stats_orphan, 32'd1);
        chk("E_in0_pkt", stats_in_pkt0, 32'd10);
        chk("E_in0_sop", stats_in_pkt0_s, 32'd10);
        chk("E_in1_pkt", stats_in_pkt1, 32'd9);
        chk("E_in1_sop", stats_in_pkt1_s, 32'd9);
        chk("E_out_pkt", stats_out_pkt, 32'd19);
        chk("E_out_sop", stats_out_pkt_s, 32'd19);

        // Reset mid-packet
        drv0(1, 1, 0, 32'hF0);
        tick();
        drv0(1, 0, 0, 32'hF1);
        tick();
        chk("F_b1", {out_valid_o, 31'(out_data_o)}, {1'b1, 31'hF1});
        drv0(1, 0, 0, 32'hF2);
        #2;
        Rst_n = 1'b0;
        #1;
        chk("F_async_valid", 32'(out_valid_o), 32'd0);
        chk("F_async_data", out_data_o, 32'd0);
        chk("F_rst_out", stats_out_pkt, 32'd0);
        chk("F_rst_in0", stats_in_pkt0_s, 32'd0);
        chk("F_rst_orphan", stats_orphan, 32'd0);
        tick();
        Rst_n = 1'b1;
        drv1(1, 1, 1, 32'h60);
        #1;
        chk("F_rdy", {30'd0, in0_ready_o, in1_ready_o}, 32'd1);
        tick();
        chk("F_g0", {out_valid_o, 31'(out_data_o)}, {1'b1, 31'h60});
        chk("F_g0_ch", 32'(out_channel_o), 32'd1);
        drv1(0, 0, 0, 32'h0);
        #1;
        chk("F_orph_rdy", 32'(in0_ready_o), 32'd1);
        tick();
        drv0(0, 0, 0, 32'h0);
        chk("F_no_out", 32'(out_valid_o), 32'd0);
        chk("F_orphan", stats_orphan, 32'd1);
        chk("F_in1_pkt", stats_in_pkt1, 32'd1);
        chk("F_in0_pkt", stats_in_pkt0, 32'd0);
        tick();
        chk("F_out_pkt", stats_out_pkt, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/merge_avlstrm.md
Name: merge_avlstrm

Overview:
- Packet-atomic 2:1 merge of Avalon-ST packet streams; the inverse of the fork service.
- Two upstream producers are arbitrated round-robin at packet granularity onto one downstream consumer, through a single registered output stage.
- Per-port packet statistics are exported to the stats/CSR path.
- Used wherever two pipeline branches rejoin, for example after a fork-and-process stage.

Parameters:
- DW, 512, data width in bits.
- EW, 6, empty field width in bits; must equal log2(DW/8).
- CW, 1, channel width in bits.
- TAG_CHANNEL, 1: 1 means out.channel carries the source index in bit 0, with upper bits zero; 0 means the input channel passes through unchanged.

Ports:
- Clk  in  1  single clock for the block.
- Rst_n  in  1  asynchronous, active-low reset.
- in0  avl_stream_if.rx  DW/EW/CW  upstream stream 0.
- in1  avl_stream_if.rx  DW/EW/CW  upstream stream 1.
- out  avl_stream_if.tx  DW/EW/CW  merged downstream stream.
- stats_in_pkt0, stats_in_pkt1, stats_out_pkt  out  32 each  accepted eop beats per port.
- stats_in_pkt0_s, stats_in_pkt1_s, stats_out_pkt_s  out  32 each  accepted sop beats per port.
- stats_orphan  out  32  non-sop beats discarded while unlocked.

Behaviour:
- Reset (async, Rst_n=0):
  - State goes to IDLE and the RR pointer to 0, so in0 has priority first.
  - out.valid=0; out.data, empty, channel, sop and eop all 0.
  - All stats counters go to 0.
- Beat acceptance: a beat is accepted on inX when inX.valid && inX.ready. The output beat transfers when out.valid && out.ready.
- Output stage: one register. load = !out.valid || out.ready. Latency is 1 cycle from input accept to out.valid. There is no bubble between packets when back-to-back sop beats are pending.
- inX.ready = load && (grant==X), where grant is combinational from the state and the RR pointer. The non-granted input's ready is 0.
- inX.almost_full = out.almost_full, forwarded unregistered to both inputs.
- FSM states:
  - IDLE: no packet is locked.
  - LOCK0: a packet from in0 is locked.
  - LOCK1: a packet from in1 is locked.
- IDLE grant selection:
  - Candidates are inputs with valid && sop.
  - If only one is a candidate, grant it.
  - If both are candidates, grant the RR pointer's input.
  - If neither is a candidate but some input is valid without sop (orphan), grant the orphan input, pointer's input first. Its beat is accepted and discarded, never loaded into the output, and stats_orphan increments. The state stays IDLE.
- IDLE transitions on an accepted sop beat from X:
  - If the beat has eop=1 (single-beat packet), the state stays IDLE and the pointer becomes !X.
  - Otherwise the state goes to LOCKX.
- LOCKX:
  - Grant is X only; the other input stalls regardless of its valid.
  - An accepted beat with eop returns the state to IDLE and sets the pointer to !X.
  - A sop beat seen mid-packet is forwarded as-is; there is no re-sync.
- Fairness: with both inputs saturated, packets alternate 0,1,0,1,…
- Channel: see TAG_CHANNEL. Data, empty, sop and eop are copied unmodified.
- Stats: counters wrap modulo 2^32. Input counters count accepted beats, excluding orphans. The output counter counts out transfers.
- Reset asserted mid-packet: the partial packet is lost and out.valid drops immediately. After release the block waits for a fresh sop.
- Simultaneous events:
  - An eop in LOCKX and a new sop at the other input in the same cycle: the sop is granted on the next cycle, without bubble beyond the one FSM update.
  - out.ready=0 while locked: the output register holds, and inX.ready=0.

Decomposition:
- Shared package struct_s:
  - AVL_DW=512 and AVL_EW=6 constants.
  - merge_state_t enum {IDLE, LOCK0, LOCK1}.
- Sub-module: reuse the existing stats_cnt, with three instances (in0, in1, out).
- Orphan counter is an inline 32-bit register.

Test Plan:
- Only in0 sends a 3-beat packet (sop cycle 0, eop cycle 2), out.ready=1 → out beats at cycles 1–3 with channel=0; stats_in_pkt0=1, stats_out_pkt=1.
- Both inputs present 4-beat packets continuously for 8 packets → output order 0,1,0,1,…; no interleaved beats within a packet; stats_out_pkt=8, stats_out_pkt_s=8.
- Single-beat packets (sop=eop=1) on both inputs every cycle → 1 beat per cycle alternating channel 0/1; no bubbles after the first.
- in0 locked mid-packet, out.ready low for 5 cycles → out.data held stable and in0.ready=in1.ready=0 for 5 cycles; resume drains the packet with no beat lost.
- in1 sends a non-sop beat while IDLE → in1.ready=1 that cycle, out.valid stays 0, stats_orphan=1.
- Rst_n pulsed low during beat 2 of a 4-beat packet → out.valid=0 asynchronously, all stats=0; the next sop on in1 is granted first after the pointer reset, with a 1-cycle latency.
